// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter, the fetch/execute phase bit and a small
// return-address stack. The instruction control logic supplies the decoded
// PC-select, call and halt controls; this block returns the current PC and
// phase to that logic and to instruction memory.
//
// Ports
//   clk       in   system clock, rising-edge
//   rst_n     in   asynchronous active-low reset
//   PS        in   PC select: 00 hold, 01 increment, 10 relative branch, 11 return
//   MP        in   call: push return address and branch relative
//   IL        in   instruction-load strobe, checked for phase consistency only
//   halt      in   end-of-execution request (execute phase, PS=00)
//   offset    in   signed two's-complement branch offset
//   state     out  phase: 0 = fetch, 1 = execute
//   pc        out  current program counter (registered)
//   ret_addr  out  pc+1, combinational link value
//   sp        out  stack occupancy, 0..DEPTH
//   halted    out  sticky: sequencer stopped
//   stk_ovf   out  sticky: push attempted while full
//   stk_unf   out  sticky: pop attempted while empty
//   il_err    out  sticky: IL inconsistent with phase
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               PS,
  input  logic                     MP,
  input  logic                     IL,
  input  logic                     halt,
  input  logic [OFF_W-1:0]         offset,
  output logic                     state,
  output logic [PC_W-1:0]          pc,
  output logic [PC_W-1:0]          ret_addr,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     halted,
  output logic                     stk_ovf,
  output logic                     stk_unf,
  output logic                     il_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  localparam logic [SP_W-1:0] SP_ZERO = SP_W'(0);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_e;

  // Architectural state
  phase_e             phase_q, phase_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic               halted_q, halted_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               il_err_q, il_err_d;

  // Return-address storage; contents are don't-care after reset
  logic [PC_W-1:0]    stack_q [DEPTH];

  // Datapath helpers
  logic [PC_W-1:0]    off_ext_s;
  logic [PC_W-1:0]    ret_addr_s;
  logic [PC_W-1:0]    branch_tgt_s;
  logic [IDX_W-1:0]   push_idx_s;
  logic [IDX_W-1:0]   pop_idx_s;
  logic               push_en_s;

  // Bring the offset to PC width: sign-extend a narrow field, keep only the
  // low bits of a wide one. Either way the sum wraps modulo 2^PC_W.
  generate
    if (OFF_W < PC_W) begin : g_off_sext
      assign off_ext_s = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    end else begin : g_off_trunc
      assign off_ext_s = offset[PC_W-1:0];
    end
  endgenerate

  assign ret_addr_s   = pc_q + PC_ONE;
  assign branch_tgt_s = pc_q + PC_ONE + off_ext_s;

  // A push only happens when sp < DEPTH, so sp itself is a valid slot index;
  // a pop only uses the index when sp > 0, so sp-1 always fits.
  assign push_idx_s = IDX_W'(sp_q);
  assign pop_idx_s  = IDX_W'(sp_q - SP_ONE);

  // State register: phase, PC, stack pointer and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_FETCH;
      pc_q     <= '0;
      sp_q     <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      il_err_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      il_err_q <= il_err_d;
    end
  end

  // Stack write port: store the link value on a non-overflowing call
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      stack_q[push_idx_s] <= ret_addr_s;
    end
  end

  // Next-state logic: phase sequencing and execute-phase PC priority
  always_comb begin
    phase_d   = phase_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    halted_d  = halted_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    il_err_d  = il_err_q;
    push_en_s = 1'b0;

    if (halted_q) begin
      // Stopped: everything freezes until reset.
      phase_d = phase_q;
    end else begin
      case (phase_q)
        PH_FETCH: begin
          phase_d = PH_EXEC;
          if (!IL) begin
            il_err_d = 1'b1;
          end else begin
            il_err_d = il_err_q;
          end
        end

        PH_EXEC: begin
          phase_d = PH_FETCH;
          if (IL) begin
            il_err_d = 1'b1;
          end else begin
            il_err_d = il_err_q;
          end

          if (MP) begin
            // A call always branches, even when the link cannot be stored.
            pc_d = branch_tgt_s;
            if (sp_q == SP_FULL) begin
              ovf_d = 1'b1;
            end else begin
              push_en_s = 1'b1;
              sp_d      = sp_q + SP_ONE;
            end
          end else begin
            case (PS)
              2'b11: begin
                if (sp_q != SP_ZERO) begin
                  pc_d = stack_q[pop_idx_s];
                  sp_d = sp_q - SP_ONE;
                end else begin
                  unf_d = 1'b1;
                  pc_d  = ret_addr_s;
                end
              end
              2'b10: pc_d = branch_tgt_s;
              2'b01: pc_d = ret_addr_s;
              2'b00: begin
                // Halting keeps the phase in execute so the frozen state
                // reflects the instruction that stopped the machine.
                if (halt) begin
                  halted_d = 1'b1;
                  phase_d  = PH_EXEC;
                end else begin
                  halted_d = halted_q;
                end
              end
              default: pc_d = pc_q;
            endcase
          end
        end

        default: phase_d = PH_FETCH;
      endcase
    end
  end

  // Output logic: all status comes straight from registers; ret_addr is the
  // only combinational output.
  always_comb begin
    state    = phase_q;
    pc       = pc_q;
    ret_addr = ret_addr_s;
    sp       = sp_q;
    halted   = halted_q;
    stk_ovf  = ovf_q;
    stk_unf  = unf_q;
    il_err   = il_err_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer (PC_W=8, OFF_W=8, DEPTH=4). A
// behavioural model built from integers and a queue tracks the expected
// phase, PC, stack and flags; every output is compared after each clock.
// Directed sequences cover the listed scenarios, followed by randomized bursts.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int PC_W  = 8;
  localparam int OFF_W = 8;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << PC_W) - 1;

  logic               clk;
  logic               rst_n;
  logic [1:0]         PS;
  logic               MP;
  logic               IL;
  logic               halt;
  logic [OFF_W-1:0]   offset;
  logic               state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    ret_addr;
  logic [2:0]         sp;
  logic               halted;
  logic               stk_ovf;
  logic               stk_unf;
  logic               il_err;

  int n_checks;
  int n_errors;

  // Reference model state
  int m_state;
  int m_pc;
  int m_halted;
  int m_ovf;
  int m_unf;
  int m_il;
  int m_stk[$];

  pc_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .PS       (PS),
    .MP       (MP),
    .IL       (IL),
    .halt     (halt),
    .offset   (offset),
    .state    (state),
    .pc       (pc),
    .ret_addr (ret_addr),
    .sp       (sp),
    .halted   (halted),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf),
    .il_err   (il_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_pc     = 0;
    m_halted = 0;
    m_ovf    = 0;
    m_unf    = 0;
    m_il     = 0;
    m_stk.delete();
  endtask

  // One clock of the sequencer, straight from the behavioural rules.
  task automatic model_step(input logic [1:0] ps, input logic mp, input logic il,
                            input logic hlt, input logic [OFF_W-1:0] off);
    int soff;
    soff = int'($signed(off));
    if (m_halted == 0) begin
      if (m_state == 0) begin
        if (il == 1'b0) m_il = 1;
        m_state = 1;
      end else begin
        if (il == 1'b1) m_il = 1;
        if (mp) begin
          if (m_stk.size() == DEPTH) m_ovf = 1;
          else m_stk.push_back((m_pc + 1) & MASK);
          m_pc = (m_pc + 1 + soff) & MASK;
        end else if (ps == 2'd3) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_unf = 1;
            m_pc  = (m_pc + 1) & MASK;
          end
        end else if (ps == 2'd2) begin
          m_pc = (m_pc + 1 + soff) & MASK;
        end else if (ps == 2'd1) begin
          m_pc = (m_pc + 1) & MASK;
        end else if (hlt) begin
          m_halted = 1;
        end
        if (m_halted == 0) m_state = 0;
      end
    end
  endtask

  task automatic check_all();
    check_eq("state",    32'(state),    32'(m_state));
    check_eq("pc",       32'(pc),       32'(m_pc));
    check_eq("ret_addr", 32'(ret_addr), 32'((m_pc + 1) & MASK));
    check_eq("sp",       32'(sp),       32'(m_stk.size()));
    check_eq("halted",   32'(halted),   32'(m_halted));
    check_eq("stk_ovf",  32'(stk_ovf),  32'(m_ovf));
    check_eq("stk_unf",  32'(stk_unf),  32'(m_unf));
    check_eq("il_err",   32'(il_err),   32'(m_il));
  endtask

  // Called at a falling edge: drive, clock, compare at the next falling edge.
  task automatic cycle(input logic [1:0] ps, input logic mp, input logic il,
                       input logic hlt, input logic [OFF_W-1:0] off);
    PS = ps; MP = mp; IL = il; halt = hlt; offset = off;
    model_step(ps, mp, il, hlt, off);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Fetch with junk controls (must be ignored), then execute the given op.
  task automatic exec_op(input logic [1:0] ps, input logic mp, input logic hlt,
                         input logic [OFF_W-1:0] off);
    cycle(2'($urandom), 1'($urandom), 1'b1, 1'($urandom), 8'($urandom));
    cycle(ps, mp, 1'b0, hlt, off);
  endtask

  // Asynchronous reset asserted between clock edges, released at a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_pc",     32'(pc),     32'h0);
    check_eq("rst_state",  32'(state),  32'h0);
    check_eq("rst_halted", 32'(halted), 32'h0);
    check_eq("rst_sp",     32'(sp),     32'h0);
    check_eq("rst_flags",  32'({stk_ovf, stk_unf, il_err}), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    logic [PC_W-1:0] frz_pc;
    logic [2:0]      frz_sp;
    logic            il_v;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; PS = 2'b00; MP = 1'b0; IL = 1'b1; halt = 1'b0; offset = 8'h00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Straight-line increments
    for (int i = 0; i < 3; i++) exec_op(2'b01, 1'b0, 1'b0, 8'h00);
    check_eq("line_pc",    32'(pc),    32'h3);
    check_eq("line_state", 32'(state), 32'h0);

    // Branch wrap: get to 0xFE, then +3 and -4
    exec_op(2'b10, 1'b0, 1'b0, 8'(8'hFE - 8'(m_pc) - 8'h01));
    check_eq("wrap_setup", 32'(pc), 32'hFE);
    exec_op(2'b10, 1'b0, 1'b0, 8'h03);
    check_eq("wrap_fwd", 32'(pc), 32'h02);
    exec_op(2'b10, 1'b0, 1'b0, 8'hFC);
    check_eq("wrap_back", 32'(pc), 32'hFF);

    // Call and return
    exec_op(2'b10, 1'b0, 1'b0, 8'h10);
    check_eq("call_setup", 32'(pc), 32'h10);
    exec_op(2'b00, 1'b1, 1'b0, 8'h20);
    check_eq("call_pc", 32'(pc), 32'h31);
    check_eq("call_sp", 32'(sp), 32'h1);
    exec_op(2'b11, 1'b0, 1'b0, 8'h00);
    check_eq("ret_pc", 32'(pc), 32'h11);
    check_eq("ret_sp", 32'(sp), 32'h0);

    // Stack limits: five calls then five returns
    for (int i = 0; i < 5; i++) exec_op(2'b00, 1'b1, 1'b0, 8'h05);
    check_eq("ovf_sp",   32'(sp),      32'h4);
    check_eq("ovf_flag", 32'(stk_ovf), 32'h1);
    for (int i = 0; i < 5; i++) exec_op(2'b11, 1'b0, 1'b0, 8'h00);
    check_eq("unf_sp",   32'(sp),      32'h0);
    check_eq("unf_flag", 32'(stk_unf), 32'h1);

    // Call wins over a simultaneous return
    do_reset();
    exec_op(2'b00, 1'b1, 1'b0, 8'h04);
    exec_op(2'b00, 1'b1, 1'b0, 8'h07);
    exec_op(2'b11, 1'b1, 1'b0, 8'h02);
    check_eq("mp_ps_sp", 32'(sp), 32'h3);
    check_eq("mp_ps_unf", 32'(stk_unf), 32'h0);

    // Halt and freeze for 10 cycles
    exec_op(2'b00, 1'b0, 1'b1, 8'h00);
    check_eq("halt_flag",  32'(halted), 32'h1);
    check_eq("halt_state", 32'(state),  32'h1);
    frz_pc = pc;
    frz_sp = sp;
    for (int i = 0; i < 10; i++)
      cycle(2'($urandom), 1'($urandom), 1'b0, 1'($urandom), 8'($urandom));
    check_eq("frz_pc",    32'(pc),    32'(frz_pc));
    check_eq("frz_sp",    32'(sp),    32'(frz_sp));
    check_eq("frz_state", 32'(state), 32'h1);

    // Reset in the middle of an execute phase, then IL=0 during fetch
    do_reset();
    cycle(2'b01, 1'b0, 1'b1, 1'b0, 8'h00);
    do_reset();
    check_eq("post_rst_state", 32'(state), 32'h0);
    cycle(2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("il_fetch", 32'(il_err), 32'h1);

    // Randomized bursts, each started by a mid-cycle reset
    for (int b = 0; b < 10; b++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        il_v = (m_state == 0) ? 1'b1 : 1'b0;
        if (m_halted == 0 && $urandom_range(0, 24) == 0) il_v = ~il_v;
        cycle(2'($urandom),
              ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
              il_v,
              ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
              8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
